// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and defaults for the register-file write arbiter
package rf_arb_pkg;

    localparam int DEF_N            = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic {
        SRC_WB = 1'b0,
        SRC_MD = 1'b1
    } rf_src_e;

    typedef struct packed {
        logic [$clog2(DEF_N)-1:0] addr;
        logic [DEF_N-1:0]         data;
    } rf_write_t;

endpackage

// File: rtl/rf_arb_starve_ctr.sv
// rtl/rf_arb_starve_ctr.sv - saturating blocked-cycle counter for the low-priority write port
module rf_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == CW'(LIMIT));

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-port register-file write arbiter with registered write output
// Optional anti-starvation guard for port 1 enabled by RF_ARB_STARVE_GUARD_EN.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [$clog2(N)-1:0] req0_addr,
    input  logic [N-1:0]         req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [$clog2(N)-1:0] req1_addr,
    input  logic [N-1:0]         req1_data,
    output logic                 rf_we,
    output logic [$clog2(N)-1:0] rf_waddr,
    output logic [N-1:0]         rf_wdata,
    output logic                 grant_src
);

    localparam int AW = $clog2(N);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    logic    forced;
    logic    fire0;
    logic    fire1;
    rf_src_e src_q;

`ifdef RF_ARB_STARVE_GUARD_EN
    // Counter clears whenever port 1 is idle or transfers, so forced mode lasts one cycle.
    rf_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (CLK),
        .rst     (RESET),
        .clr     (!req1_valid || req1_ready),
        .inc     (req1_valid && !req1_ready),
        .at_limit(forced)
    );
`else
    assign forced = 1'b0;
`endif

    assign req0_ready = !forced;
    assign req1_ready = forced || !req0_valid;

    assign fire0 = req0_valid && req0_ready;
    assign fire1 = req1_valid && req1_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            src_q    <= SRC_WB;
        end else if (fire0) begin
            rf_we    <= (req0_addr != '0);
            rf_waddr <= req0_addr;
            rf_wdata <= req0_data;
            src_q    <= SRC_WB;
        end else if (fire1) begin
            rf_we    <= (req1_addr != '0);
            rf_waddr <= req1_addr;
            rf_wdata <= req1_data;
            src_q    <= SRC_MD;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign grant_src = src_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int N     = DEF_N;
    localparam int AW    = $clog2(N);
    localparam int LIMIT = DEF_STARVE_LIMIT;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [N-1:0]  req0_data = '0, req1_data = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic          grant_src;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(.N(N), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_src(grant_src)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v0, input logic [AW-1:0] a0, input logic [N-1:0] d0,
                          input logic v1, input logic [AW-1:0] a1, input logic [N-1:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Reference model state: what the write port should show, and port 1 blocked-cycle count.
    int            m_cnt;
    logic          m_we, m_src;
    logic [AW-1:0] m_addr;
    logic [N-1:0]  m_data;

    task automatic do_reset();
        set_in(0, '0, '0, 0, '0, '0);
        RESET = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
        m_cnt = 0; m_we = 0; m_src = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_step(input logic v0, input logic [AW-1:0] a0, input logic [N-1:0] d0,
                              input logic v1, input logic [AW-1:0] a1, input logic [N-1:0] d1,
                              output logic f0, output logic f1);
        logic forced, e_r0, e_r1;
        set_in(v0, a0, d0, v1, a1, d1);
        #1;
        forced = GUARD && (m_cnt == LIMIT);
        e_r0 = !forced;
        e_r1 = forced || !v0;
        chk("rnd_ready0", req0_ready, e_r0);
        chk("rnd_ready1", req1_ready, e_r1);
        f0 = v0 && e_r0;
        f1 = v1 && e_r1 && !f0;
        if (f0) begin
            m_we = (a0 != 0); m_addr = a0; m_data = d0; m_src = 0;
        end else if (f1) begin
            m_we = (a1 != 0); m_addr = a1; m_data = d1; m_src = 1;
        end else begin
            m_we = 0;
        end
        if (!v1 || f1) m_cnt = 0;
        else if (m_cnt < LIMIT) m_cnt++;
        @(posedge CLK); #1;
        chk("rnd_we", rf_we, m_we);
        chk("rnd_waddr", rf_waddr, m_addr);
        chk("rnd_wdata", rf_wdata, m_data);
        chk("rnd_src", grant_src, m_src);
    endtask

    typedef struct {
        logic          v0; logic [AW-1:0] a0; logic [N-1:0] d0;
        logic          v1; logic [AW-1:0] a1; logic [N-1:0] d1;
        logic          r0, r1, we; logic [AW-1:0] addr; logic [N-1:0] data; logic src;
    } vec_t;

    function automatic vec_t mk(input logic v0, input int a0, input logic [N-1:0] d0,
                                input logic v1, input int a1, input logic [N-1:0] d1,
                                input logic r0, input logic r1, input logic we,
                                input int addr, input logic [N-1:0] data, input logic src);
        vec_t v;
        v.v0 = v0; v.a0 = AW'(a0); v.d0 = d0; v.v1 = v1; v.a1 = AW'(a1); v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.we = we; v.addr = AW'(addr); v.data = data; v.src = src;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        logic          f0, f1;
        logic          p0_v, p1_v;
        logic [AW-1:0] p0_a, p1_a;
        logic [N-1:0]  p0_d, p1_d;
        int            acc1;

        tbl[0] = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        1, 0, 1, 5, 32'hDEADBEEF, 0);
        tbl[1] = mk(1, 3, 32'h11,       1, 4, 32'h22,   1, 0, 1, 3, 32'h11,       0);
        tbl[2] = mk(0, 0, 0,            1, 4, 32'h22,   1, 1, 1, 4, 32'h22,       1);
        tbl[3] = mk(1, 0, 32'hFFFF,     0, 0, 0,        1, 0, 0, 0, 32'hFFFF,     0);
        tbl[4] = mk(0, 0, 0,            0, 0, 0,        1, 1, 0, 0, 32'hFFFF,     0);
        tbl[5] = mk(0, 0, 0,            1, 7, 32'h77,   1, 1, 1, 7, 32'h77,       1);
        tbl[6] = mk(0, 0, 0,            1, 0, 32'h5,    1, 1, 0, 0, 32'h5,        1);
        tbl[7] = mk(0, 0, 0,            0, 0, 0,        1, 1, 0, 0, 32'h5,        1);

        // Reset state
        #12;
        chk("reset_we", rf_we, 0);
        chk("reset_waddr", rf_waddr, 0);
        chk("reset_wdata", rf_wdata, 0);
        chk("reset_src", grant_src, 0);
        chk("reset_ready0", req0_ready, 1);
        chk("reset_ready1", req1_ready, 1);
        do_reset();

        foreach (tbl[i]) begin
            set_in(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
            @(posedge CLK); #1;
            chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].we);
            chk($sformatf("tbl%0d_waddr", i), rf_waddr, tbl[i].addr);
            chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].data);
            chk($sformatf("tbl%0d_src", i), grant_src, tbl[i].src);
        end

        // Port 0 busy every cycle while port 1 waits
        do_reset();
`ifdef RF_ARB_STARVE_GUARD_EN
        for (int c = 1; c <= LIMIT + 2; c++) begin
            set_in(1, AW'(c), N'(c), 1, AW'(2), 32'hABC);
            #1;
            chk($sformatf("starve_c%0d_ready0", c), req0_ready, (c != LIMIT + 1));
            chk($sformatf("starve_c%0d_ready1", c), req1_ready, (c == LIMIT + 1));
            @(posedge CLK); #1;
            if (c == LIMIT + 1) begin
                chk("starve_forced_src", grant_src, 1);
                chk("starve_forced_addr", rf_waddr, 2);
                chk("starve_forced_we", rf_we, 1);
            end
        end
`else
        acc1 = 0;
        for (int c = 0; c < 100; c++) begin
            set_in(1, AW'(c % 31 + 1), N'(c), 1, AW'(2), 32'hABC);
            #1;
            if (req1_ready) acc1++;
            @(posedge CLK); #1;
            if (grant_src) acc1++;
        end
        chk("strict_priority_port1_accepts", acc1, 0);
`endif

        // Asynchronous reset while a write is on the port
        do_reset();
        set_in(1, 9, 32'h1234, 0, 0, 0);
        @(posedge CLK); #1;
        chk("midrst_pre_we", rf_we, 1);
        #2 RESET = 1'b1;
        #1;
        chk("midrst_we", rf_we, 0);
        chk("midrst_waddr", rf_waddr, 0);
        chk("midrst_wdata", rf_wdata, 0);
        chk("midrst_src", grant_src, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        set_in(1, 10, 32'h55, 0, 0, 0);
        @(posedge CLK); #1;
        chk("midrst_resume_we", rf_we, 1);
        chk("midrst_resume_waddr", rf_waddr, 10);
        chk("midrst_resume_wdata", rf_wdata, 32'h55);

        // Randomised traffic, requesters holding until accepted
        do_reset();
        p0_v = 0; p1_v = 0; p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!p0_v) begin
                p0_v = ($urandom_range(0, 9) < 7);
                p0_a = AW'($urandom_range(0, N - 1));
                p0_d = $urandom;
            end
            if (!p1_v) begin
                p1_v = ($urandom_range(0, 9) < 6);
                p1_a = AW'($urandom_range(0, N - 1));
                p1_d = $urandom;
            end
            model_step(p0_v, p0_a, p0_d, p1_v, p1_a, p1_d, f0, f1);
            if (f0) p0_v = 0;
            if (f1) p1_v = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
